// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions used by the memory stage.
//   - size codes for load/store width
//   - memory-stage FSM state type
//   - default bus acknowledge timeout
//   - helpers for alignment, byte enables and store lane replication
package mips_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int ME_ACK_TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        ME_IDLE = 2'd0,
        ME_BUSY = 2'd1,
        ME_DONE = 2'd2
    } me_state_t;

    // Reserved size is treated as misaligned so it raises an address error.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~addr_lo[0];
            SZ_WORD: ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Little-endian lane k = bits 8k+7:8k; same encoding for reads and writes.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Right-justified store data replicated into every lane it may land in.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            SZ_BYTE: d = {4{wdata[7:0]}};
            SZ_HALF: d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/me_load_align.sv
// Load data alignment: selects the addressed byte/halfword lane of a read
// word and sign- or zero-extends it to 32 bits.
// Ports:
//   i_rdata    - word returned by data memory
//   i_addr_lo  - byte address bits [1:0]
//   i_size     - access size code
//   i_unsigned - 1 = zero-extend, 0 = sign-extend
//   o_data     - extended load result
module me_load_align
    import mips_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_size)
            SZ_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/me_dmem_access.sv
// Memory-stage data-memory access controller. Issues a registered req/ack
// bus request for the load/store held in EX/ME, stalls the pipeline until the
// access completes or times out, and returns extended load data.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   ex_*                - instruction fields from the EX/ME register
//   mem_req/we/addr/be/wdata, mem_ack, mem_rdata - data-memory port
//                         (mem_req rises and all fields stay stable until the
//                         one-cycle mem_ack pulse, or until timeout)
//   me_stall            - freeze IF..EX/ME, bubble into ME/WB
//   me_dmdata           - extended load data, held until the next load
//   me_exc              - misaligned / reserved-size address error
//   me_err              - bus timeout, high for the DONE cycle only
//   dbg_state           - current FSM state (me_state_t encoding)
module me_dmem_access
    import mips_pkg::*;
#(
    parameter int ACK_TIMEOUT = ME_ACK_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_mem_rd,
    input  logic        ex_mem_wr,
    input  logic [1:0]  ex_size,
    input  logic        ex_unsigned,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        me_stall,
    output logic [31:0] me_dmdata,
    output logic        me_exc,
    output logic        me_err,
    output logic [1:0]  dbg_state
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    me_state_t   r_state;
    me_state_t   w_next;
    logic        w_is_mem;
    logic        w_aligned;
    logic        w_start;
    logic        w_timeout;
    logic [31:0] w_ld_data;

    logic          r_req;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [3:0]    r_be;
    logic [31:0]   r_wdata;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_dmdata;
    logic          r_err;
    // Load attributes captured at issue so extraction does not depend on
    // EX/ME staying frozen.
    logic          r_rd;
    logic [1:0]    r_size;
    logic          r_uns;
    logic [1:0]    r_lo;

    assign w_is_mem  = ex_valid & (ex_mem_rd | ex_mem_wr);
    assign w_aligned = is_aligned(ex_size, ex_addr[1:0]);
    assign w_start   = w_is_mem & w_aligned;

    assign me_exc    = w_is_mem & ~w_aligned;
    assign me_stall  = ((r_state == ME_IDLE) & w_start) | (r_state == ME_BUSY);

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            ME_IDLE: if (w_start) w_next = ME_BUSY;
            ME_BUSY: begin
                // A real ack wins over a timeout landing in the same cycle.
                if (mem_ack) begin
                    w_next = ME_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_next    = ME_DONE;
                    w_timeout = 1'b1;
                end
            end
            // DONE never restarts: the same instruction is still on ex_*.
            ME_DONE: w_next = ME_IDLE;
            default: w_next = ME_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ME_IDLE;
        else     r_state <= w_next;
    end

    me_load_align u_load_align (
        .i_rdata    (mem_rdata),
        .i_addr_lo  (r_lo),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .o_data     (w_ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_be     <= '0;
            r_wdata  <= '0;
            r_cnt    <= '0;
            r_rd     <= 1'b0;
            r_size   <= SZ_BYTE;
            r_uns    <= 1'b0;
            r_lo     <= 2'b00;
            r_dmdata <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (r_state == ME_IDLE && w_start) begin
                r_req   <= 1'b1;
                r_we    <= ex_mem_wr;
                r_addr  <= {ex_addr[31:2], 2'b00};
                r_be    <= byte_en(ex_size, ex_addr[1:0]);
                r_wdata <= lane_wdata(ex_size, ex_wdata);
                r_cnt   <= '0;
                r_rd    <= ex_mem_rd;
                r_size  <= ex_size;
                r_uns   <= ex_unsigned;
                r_lo    <= ex_addr[1:0];
            end else if (r_state == ME_BUSY) begin
                if (mem_ack || w_timeout) begin
                    r_req <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (mem_ack && r_rd) r_dmdata <= w_ld_data;
            end
        end
    end

    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_be    = r_be;
    assign mem_wdata = r_wdata;
    assign me_dmdata = r_dmdata;
    assign me_err    = r_err;
    assign dbg_state = r_state;

endmodule

// File: doc/me_dmem_access.md
# me_dmem_access

Memory-stage data-memory access controller for the five-stage MIPS pipeline. It takes the load/store request held in the EX/ME pipeline register and drives a variable-latency req/ack data-memory port. It stalls the pipeline until the access completes, then presents aligned, sign- or zero-extended load data as `me_dmdata`. That output feeds the ME/WB pipeline register's `ME_DMData` input.

## Interface
- `ACK_TIMEOUT`, default 255: maximum cycles in BUSY before the access is aborted with an error.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `ex_valid` in 1: EX/ME register holds a valid instruction.
- `ex_mem_rd` in 1: instruction is a load.
- `ex_mem_wr` in 1: instruction is a store. Never asserted together with `ex_mem_rd`.
- `ex_size` in 2: 00 byte, 01 halfword, 10 word, 11 reserved.
- `ex_unsigned` in 1: zero-extend the load (LBU/LHU); otherwise sign-extend.
- `ex_addr` in 32: effective byte address (ALU result).
- `ex_wdata` in 32: store data, right-justified.
- `mem_req` out 1: access request, registered.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: word address, `{ex_addr[31:2],2'b00}`.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ack` in 1: one-cycle completion pulse from memory.
- `mem_rdata` in 32: read word, valid with `mem_ack`.
- `me_stall` out 1: freeze IF..EX/ME; insert a bubble into ME/WB.
- `me_dmdata` out 32: extended load data, registered.
- `me_exc` out 1: misaligned or reserved-size access (address error).
- `me_err` out 1: bus timeout on the current access.

## Operation
- **States:** IDLE, BUSY, DONE.
- **IDLE.**
  - `start` = `ex_valid & (ex_mem_rd|ex_mem_wr) & aligned`.
  - On `start`: register `mem_req`=1, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata`; clear the timeout counter; go to BUSY.
- **BUSY.**
  - `mem_req` and all request fields held stable until `mem_ack`.
  - On `mem_ack`: drop `mem_req`. For a load, capture the extracted data into `me_dmdata`. Go to DONE.
  - If the counter reaches `ACK_TIMEOUT` without `mem_ack`: drop `mem_req`, set `me_err`, go to DONE.
- **DONE.** One cycle; the pipeline advances at the end of it. Always returns to IDLE, and never restarts on the still-visible current instruction.
- **Alignment.**
  - Halfword requires `addr[0]`=0; word requires `addr[1:0]`=0; size 11 is always misaligned.
  - A misaligned access raises `me_exc` combinationally while `ex_valid` is high. No request and no stall.
- **Byte enables** (little-endian; lane k = bits `8k+7:8k`):
  - Byte: `1<<addr[1:0]`.
  - Halfword: `addr[1] ? 1100 : 0011`.
  - Word: `1111`.
  - Same encoding for reads.
- **Write data:** byte replicated ×4; halfword replicated ×2; word as-is.
- **Load extraction:** select the lane by `addr[1:0]` (byte) or `addr[1]` (half), then sign- or zero-extend to 32 bits.
- **`me_dmdata` hold:** held until the next completed load. Stores and timeouts leave it unchanged.
- **Non-memory instructions:** `ex_valid` low or no rd/wr gives no action: stall 0, IDLE.

## Timing
- **Reset values:** state IDLE, `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_be` 0, `mem_wdata` 0, `me_dmdata` 0, `me_err` 0, counter 0.
- **Reset mid-access:** asynchronous reset drops `mem_req` immediately. Any later `mem_ack` is ignored in IDLE.
- **`me_stall`** = `(IDLE & start) | BUSY`, combinational. It is 0 in DONE.
- **Latency:** access with ack N cycles after `mem_req` rises (N≥1) gives a stall of N+1 cycles. `me_dmdata` is valid in the DONE cycle and after.
- **Back-to-back accesses:** the second request issues in the cycle after DONE; minimum 3 cycles per access.
- **`me_err`:** high during DONE only; clears on return to IDLE.
- **Spurious ack:** `mem_ack` in IDLE or DONE is ignored.

## Structure
- **Shared package `mips_pkg`:**
  - Size codes `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`.
  - FSM state typedef `me_state_t`.
  - Default `ACK_TIMEOUT`.
- **Sub-module `me_load_align`:** combinational lane select plus sign/zero extension (`rdata`, `addr[1:0]`, `size`, `unsigned` → `data`). Reused by the verification model.

## Test plan
- LW, addr 0x100, ack 2 cycles after req → `mem_be`=1111, `mem_addr`=0x100, stall 3 cycles, `me_dmdata`=`mem_rdata`.
- LB, addr 0x103, rdata 0x80FF_0000 → `mem_be`=1000, `me_dmdata`=0xFFFF_FF80. Same with LBU → 0x0000_0080.
- SH, addr 0x202, wdata 0x1234_ABCD → `mem_we`=1, `mem_be`=1100, `mem_wdata`=0xABCD_ABCD, `me_dmdata` unchanged.
- LW, addr 0x101 → `me_exc`=1, `mem_req` stays 0, `me_stall`=0. Size 11 at 0x100 → same.
- ACK_TIMEOUT=4, no ack → `mem_req` drops after 4 BUSY cycles, `me_err`=1 for one cycle, then IDLE.
- `rst` asserted in BUSY → `mem_req`=0 at once. A late `mem_ack` is ignored. The next LW completes normally.
